// File: rtl/serial_nor_16.sv
// Bit-serial receiver assembling a 16-bit bitwise NOR word from two LSB-first operand streams.
// Optional `zero` flag output is built when SERIAL_NOR_ZERO_FLAG_EN is defined.
module serial_nor_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        bit_valid,
    input  logic        a_bit,
    input  logic        b_bit,
    output logic [15:0] out,
    output logic        done,
    output logic        busy
`ifdef SERIAL_NOR_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    // Handshake: bit_valid is a valid-only qualifier with no backpressure.
    // In COLLECT every edge with bit_valid=1 consumes one a_bit/b_bit pair;
    // in IDLE bit_valid is ignored and only start is looked at.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [15:0] shreg;
    logic        nor_bit;
    logic [15:0] assembled;

    // The final bit is merged combinationally so the completion edge writes the whole word.
    always_comb begin
        nor_bit   = ~(a_bit | b_bit);
        assembled = {nor_bit, shreg[14:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            shreg <= 16'h0000;
            out   <= 16'h0000;
            done  <= 1'b0;
            busy  <= 1'b0;
`ifdef SERIAL_NOR_ZERO_FLAG_EN
            zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                        count <= 4'd0;
                        shreg <= 16'h0000;
                    end
                end
                COLLECT: begin
                    if (bit_valid) begin
                        shreg[count] <= nor_bit;
                        count        <= count + 4'd1;
                        if (count == 4'd15) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            out   <= assembled;
                            count <= 4'd0;
`ifdef SERIAL_NOR_ZERO_FLAG_EN
                            zero  <= (assembled == 16'h0000);
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
